// File: rtl/bnn_pkg.sv
// Shared constants and state encoding for the binarised layer-1 engine.
package bnn_pkg;

  localparam int unsigned IN_WIDTH = 784;
  localparam int unsigned CHUNK    = 112;
  localparam int unsigned NEURONS  = 512;
  localparam int unsigned BEATS    = IN_WIDTH / CHUNK;
  localparam int unsigned CNT_W    = $clog2(IN_WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bnn_layer1_stream_engine_popcount.sv
// Masked +1/-1 counter for one weight chunk: pixels that are off contribute to neither count.
module popcount_masked #(
  parameter  int unsigned CHUNK = 112,
  localparam int unsigned PW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] w,
  input  logic [CHUNK-1:0] x,
  output logic [PW-1:0]    pos,
  output logic [PW-1:0]    neg
);

  // Count agreeing (+1) and disagreeing (-1) weights over the active pixels.
  always_comb begin
    pos = '0;
    neg = '0;
    for (int i = 0; i < CHUNK; i++) begin
      pos = pos + PW'(w[i] & x[i]);
      neg = neg + PW'(~w[i] & x[i]);
    end
  end

endmodule

// File: rtl/bnn_layer1_stream_engine.sv
// Layer-1 neuron engine: streams w1 rows in chunks against a latched image,
// emitting one binarised activation and signed score per neuron.
module bnn_layer1_stream_engine
  import bnn_pkg::*;
#(
  parameter  int unsigned IN_WIDTH = bnn_pkg::IN_WIDTH,
  parameter  int unsigned CHUNK    = bnn_pkg::CHUNK,
  parameter  int unsigned NEURONS  = bnn_pkg::NEURONS,
  localparam int unsigned CNT_W    = $clog2(IN_WIDTH + 1),
  localparam int unsigned NW       = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IN_WIDTH-1:0]     x_in,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [CHUNK-1:0]        w_data,
  output logic                    bit_valid,
  output logic [NW-1:0]           bit_index,
  output logic                    bit_value,
  output logic signed [CNT_W:0]   score,
  output logic [NEURONS-1:0]      a1_out,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned NBEATS = IN_WIDTH / CHUNK;
  localparam int unsigned KW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned PW     = $clog2(CHUNK + 1);

  state_t               state_q;
  state_t               state_d;
  logic [IN_WIDTH-1:0]  x_reg;
  logic [NW-1:0]        n;
  logic [KW-1:0]        k;
  logic [CNT_W-1:0]     pos_acc;
  logic [CNT_W-1:0]     neg_acc;

  logic                 fire;
  logic                 last_beat;
  logic                 last_neuron;
  logic [CHUNK-1:0]     xs;
  logic [PW-1:0]        pos;
  logic [PW-1:0]        neg;
  logic [CNT_W-1:0]     final_pos;
  logic [CNT_W-1:0]     final_neg;
  logic                 new_bit;
  logic signed [CNT_W:0] new_score;

  popcount_masked #(.CHUNK(CHUNK)) u_popcount (
    .w   (w_data),
    .x   (xs),
    .pos (pos),
    .neg (neg)
  );

  // Beat datapath: select the current image slice and fold in this beat's counts.
  always_comb begin
    fire        = w_ready & w_valid;
    last_beat   = (k == KW'(NBEATS - 1));
    last_neuron = (n == NW'(NEURONS - 1));
    xs          = '0;
    for (int b = 0; b < NBEATS; b++) begin
      if (k == KW'(b)) xs = x_reg[b*CHUNK +: CHUNK];
    end
    final_pos = pos_acc + CNT_W'(pos);
    final_neg = neg_acc + CNT_W'(neg);
    new_bit   = (final_pos >= final_neg);
    new_score = $signed({1'b0, final_pos}) - $signed({1'b0, final_neg});
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: start launches a pass, the final beat of the final neuron ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (fire && last_beat && last_neuron) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, accumulators and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg     <= '0;
      n         <= '0;
      k         <= '0;
      pos_acc   <= '0;
      neg_acc   <= '0;
      a1_out    <= '0;
      busy      <= 1'b0;
      w_ready   <= 1'b0;
      bit_valid <= 1'b0;
      bit_index <= '0;
      bit_value <= 1'b0;
      score     <= '0;
      done      <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= (state_d == RUN);
      w_ready   <= (state_d == RUN);
      if (state_q == IDLE && start) begin
        x_reg   <= x_in;
        a1_out  <= '0;
        n       <= '0;
        k       <= '0;
        pos_acc <= '0;
        neg_acc <= '0;
      end else if (fire) begin
        if (last_beat) begin
          pos_acc   <= '0;
          neg_acc   <= '0;
          k         <= '0;
          n         <= last_neuron ? '0 : n + NW'(1);
          bit_valid <= 1'b1;
          bit_index <= n;
          bit_value <= new_bit;
          score     <= new_score;
          done      <= last_neuron;
          for (int j = 0; j < NEURONS; j++) begin
            if (n == NW'(j)) a1_out[j] <= new_bit;
          end
        end else begin
          pos_acc <= final_pos;
          neg_acc <= final_neg;
          k       <= k + KW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bnn_layer1_stream_engine.sv
// Directed bench for the layer-1 stream engine with four neurons.
module tb_bnn_layer1_stream_engine;

  localparam int IW = 784;
  localparam int CH = 112;
  localparam int NN = 4;
  localparam int BT = IW / CH;
  localparam int TOTAL = NN * BT;

  logic              clk;
  logic              rst;
  logic              start;
  logic [IW-1:0]     x_in;
  logic              w_valid;
  logic              w_ready;
  logic [CH-1:0]     w_data;
  logic              bit_valid;
  logic [1:0]        bit_index;
  logic              bit_value;
  logic signed [10:0] score;
  logic [NN-1:0]     a1_out;
  logic              busy;
  logic              done;

  bnn_layer1_stream_engine #(.IN_WIDTH(IW), .CHUNK(CH), .NEURONS(NN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_in      (x_in),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .bit_valid (bit_valid),
    .bit_index (bit_index),
    .bit_value (bit_value),
    .score     (score),
    .a1_out    (a1_out),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [IW-1:0]         x;
    logic [NN-1:0][IW-1:0] w;
    int                    exp_score [NN];
    logic [NN-1:0]         exp_a1;
  } vec_t;

  vec_t tv [4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int   beats;
  int   rcount;
  int   done_cnt;
  int   done_cyc;
  logic done_busy;
  logic done_bv;
  int   res_idx   [NN];
  logic res_bit   [NN];
  int   res_score [NN];
  int   bv_cyc    [NN];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe handshakes and results away from the active edge.
  always @(negedge clk) begin
    if (w_valid && w_ready) beats++;
    if (bit_valid) begin
      if (rcount < NN) begin
        res_idx[rcount]   = int'(bit_index);
        res_bit[bit_index]   = bit_value;
        res_score[bit_index] = int'(score);
        bv_cyc[rcount]    = cyc;
      end
      rcount++;
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
      done_bv   = bit_valid;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    beats = 0; rcount = 0; done_cnt = 0; done_cyc = -1;
    done_busy = 1'bx; done_bv = 1'b0;
    for (int i = 0; i < NN; i++) begin
      res_idx[i] = -1; res_bit[i] = 1'bx; res_score[i] = 99999; bv_cyc[i] = -1;
    end
  endtask

  task automatic start_pass(input logic [IW-1:0] x);
    x_in = x;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer nb beats in row order; optional random gaps and a stray start mid-pass.
  task automatic feed(input logic [NN-1:0][IW-1:0] w, input int nb, input int gap,
                      input bit mid, input logic [IW-1:0] xalt);
    int  b = 0;
    int  c = 0;
    bit  take;
    while (b < nb && c < 2000) begin
      w_data  = w[b / BT][(b % BT) * CH +: CH];
      w_valid = (gap == 0) || ($urandom_range(99) >= gap);
      if (mid && b == 10) begin
        x_in  = xalt;
        start = 1'b1;
      end
      @(negedge clk);
      take = w_valid && w_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (take) b++;
      c++;
    end
    w_valid = 1'b0;
    w_data  = '0;
    if (b < nb) chk("feed_timeout", b, nb);
  endtask

  function automatic void model(input logic [IW-1:0] x, input logic [IW-1:0] w,
                                output logic b, output int s);
    int p = 0;
    int q = 0;
    for (int i = 0; i < IW; i++) begin
      if (x[i]) begin
        if (w[i]) p++;
        else      q++;
      end
    end
    s = p - q;
    b = (p >= q);
  endfunction

  task automatic check_pass(input string tag, input int exp_score [NN],
                            input logic [NN-1:0] exp_a1, input bit spacing);
    chk({tag, "_results"}, rcount, NN);
    chk({tag, "_beats"}, beats, TOTAL);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_with_last"}, done_cyc, bv_cyc[NN-1]);
    chk({tag, "_busy_at_done"}, done_busy, 0);
    chk({tag, "_a1"}, a1_out, exp_a1);
    for (int i = 0; i < NN; i++) begin
      chk($sformatf("%s_idx%0d", tag, i), res_idx[i], i);
      chk($sformatf("%s_bit%0d", tag, i), res_bit[i], exp_a1[i]);
      chk($sformatf("%s_score%0d", tag, i), res_score[i], exp_score[i]);
      if (spacing && i > 0)
        chk($sformatf("%s_gap%0d", tag, i), bv_cyc[i] - bv_cyc[i-1], BT);
    end
  endtask

  initial begin
    logic [IW-1:0]         x5;
    logic [IW-1:0]         xalt;
    logic [NN-1:0][IW-1:0] w5;
    int                    s5 [NN];
    logic [NN-1:0]         a5;
    logic                  bb;
    int                    ss;
    int                    hold;

    tv[0].x = '1; tv[0].w = '1;
    tv[0].exp_score = '{784, 784, 784, 784}; tv[0].exp_a1 = 4'b1111;
    tv[1].x = '1; tv[1].w = '0;
    tv[1].exp_score = '{-784, -784, -784, -784}; tv[1].exp_a1 = 4'b0000;
    tv[2].x = '0;
    for (int n = 0; n < NN; n++)
      for (int j = 0; j < IW; j++) tv[2].w[n][j] = 1'($urandom_range(1));
    tv[2].exp_score = '{0, 0, 0, 0}; tv[2].exp_a1 = 4'b1111;
    tv[3].x = IW'(10'h3FF);
    tv[3].w[0] = IW'(5'h1F);
    tv[3].w[1] = IW'(4'hF);
    tv[3].w[2] = '1;
    tv[3].w[3] = '0;
    tv[3].exp_score = '{0, -2, 10, -10}; tv[3].exp_a1 = 4'b0101;

    rst = 1'b1; start = 1'b0; x_in = '0; w_valid = 1'b0; w_data = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_bit_index", bit_index, 0);
    chk("rst_bit_value", bit_value, 0);
    chk("rst_score", score, 0);
    chk("rst_a1", a1_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      clear_mon();
      start_pass(tv[v].x);
      chk($sformatf("v%0d_busy_after_start", v), busy, 1);
      feed(tv[v].w, TOTAL, 0, 1'b0, '0);
      repeat (3) @(posedge clk);
      #1;
      check_pass($sformatf("v%0d", v), tv[v].exp_score, tv[v].exp_a1, 1'b1);
      if (v == 0) begin
        hold = beats;
        w_valid = 1'b1; w_data = '1;
        repeat (3) @(posedge clk);
        #1;
        w_valid = 1'b0;
        chk("idle_no_consume", beats, hold);
        chk("idle_w_ready", w_ready, 0);
        chk("idle_a1_hold", a1_out, 4'b1111);
      end
    end

    // Random data with stalls and an ignored start partway through.
    for (int j = 0; j < IW; j++) begin
      x5[j]   = 1'($urandom_range(1));
      xalt[j] = 1'($urandom_range(1));
      for (int n = 0; n < NN; n++) w5[n][j] = 1'($urandom_range(1));
    end
    for (int n = 0; n < NN; n++) begin
      model(x5, w5[n], bb, ss);
      s5[n] = ss;
      a5[n] = bb;
    end
    clear_mon();
    start_pass(x5);
    feed(w5, TOTAL, 30, 1'b1, xalt);
    repeat (3) @(posedge clk);
    #1;
    check_pass("rand", s5, a5, 1'b0);

    // Abort mid-pass with reset, then rerun the all-ones case.
    clear_mon();
    start_pass(tv[0].x);
    feed(tv[0].w, 10, 0, 1'b0, '0);
    @(negedge clk);
    chk("pre_abort_a1", a1_out, 4'b0001);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_w_ready", w_ready, 0);
    chk("abort_a1", a1_out, 0);
    chk("abort_score", score, 0);
    chk("abort_bit_value", bit_value, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    clear_mon();
    start_pass(tv[0].x);
    feed(tv[0].w, TOTAL, 0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    check_pass("rerun", tv[0].exp_score, tv[0].exp_a1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
